// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the state/dispatch encoding (the instruction decoder emits the same
// 4-bit codes on its nextstate bus), the datapath mux select constants and
// small helpers used by the controller FSM.
package multicycle_controller_pkg;

  localparam int EXMODE_WIDTH = 4;

  typedef enum logic [EXMODE_WIDTH-1:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // States that own the memory port and therefore wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s inside {FETCH1, FETCH2, FETCH3, FETCH4, LBRD, SBWR});
  endfunction

  // Each fetch state loads one byte lane of the IR; FETCH1..FETCH4 are
  // encoded 0..3, so the low two bits select the lane.
  function automatic logic [3:0] fetch_lane(input state_t s);
    return 4'b0001 << s[1:0];
  endfunction

endpackage

// File: rtl/multicycle_controller_mem_watchdog.sv
// Memory handshake watchdog.
// Counts consecutive cycles spent in a memory state without mem_ready and
// raises expire combinationally in the cycle where the count has reached
// TIMEOUT-1 and the memory still has not answered.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   active          controller is running and sits in a memory state
//   mem_ready       memory completes the current access this cycle
//   state_change    controller leaves its current state at the next edge
//   expire          abort request for the controller (this cycle)
module mem_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  input  logic state_change,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // A ready memory always wins, so expire is only raised while mem_ready
  // is still low in the final allowed cycle.
  assign expire = active && !mem_ready && (count == CNT_W'(TIMEOUT - 1));

  // The count restarts whenever the wait ends: the access completes, the
  // controller moves on, or the watchdog itself forces the abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!active || mem_ready || state_change || expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core.
// Sequences a four-byte instruction fetch, decode and the execute/writeback
// states of each supported instruction, driving every datapath strobe.
// Memory states stall on mem_ready and are aborted by mem_watchdog.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   nextstate    dispatch code from the instruction decoder
//   zero         ALU zero flag (branch decision)
//   mem_ready    memory completes the current read/write this cycle
//   pcen..aluop  datapath strobes and mux selects
//   state        current FSM state for debug
//   instr_done   pulse in the first FETCH1 cycle after a completed instruction
//   illegal      pulse while DECODE sees an unsupported dispatch code
//   mem_timeout  pulse in the FETCH1 cycle following a watchdog abort
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] nextstate,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic [3:0] irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout
);

  state_t state_q, state_d;
  logic   run;
  logic   is_load;
  logic   done_d;
  logic   instr_done_q;
  logic   mem_timeout_q;
  logic   expire;
  logic   mem_active;
  logic   state_change;

  assign state       = state_q;
  assign instr_done  = instr_done_q;
  assign mem_timeout = mem_timeout_q;

  assign mem_active   = run && is_mem_state(state_q);
  assign state_change = (state_d != state_q);

  mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .active       (mem_active),
    .mem_ready    (mem_ready),
    .state_change (state_change),
    .expire       (expire)
  );

  // run stays low for the first edge after reset release so the datapath
  // sees one fully quiet cycle before the first fetch is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH1;
      run           <= 1'b0;
      is_load       <= 1'b0;
      instr_done_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      run           <= 1'b1;
      state_q       <= state_d;
      instr_done_q  <= done_d;
      mem_timeout_q <= expire;
      if (run && state_q == DECODE) begin
        is_load <= (nextstate == LBRD);
      end
    end
  end

  // Next-state and Moore output decode. Everything defaults to idle and
  // FETCH1, so unused encodings and the not-yet-running case fall out
  // without extra logic. Only fetch strobes, BEQ pcen and illegal look at
  // inputs.
  always_comb begin
    state_d  = FETCH1;
    pcen     = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 4'b0000;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pcsrc    = PCSRC_ALU;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RT;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    done_d   = 1'b0;

    if (run) begin
      case (state_q)
        FETCH1, FETCH2, FETCH3, FETCH4: begin
          memread = 1'b1;
          alusrcb = SRCB_ONE;
          pcen    = mem_ready;
          irwrite = mem_ready ? fetch_lane(state_q) : 4'b0000;
          if (mem_ready) begin
            case (state_q)
              FETCH1:  state_d = FETCH2;
              FETCH2:  state_d = FETCH3;
              FETCH3:  state_d = FETCH4;
              default: state_d = DECODE;
            endcase
          end else if (expire) begin
            state_d = FETCH1;
          end else begin
            state_d = state_q;
          end
        end

        DECODE: begin
          alusrcb = SRCB_BOFF;
          case (nextstate)
            LBRD, SBWR:                   state_d = MEMADR;
            RTYPEEX, BEQEX, ADDIEX, JEX:  state_d = state_t'(nextstate);
            default: begin
              state_d = FETCH1;
              illegal = 1'b1;
            end
          endcase
        end

        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          state_d = is_load ? LBRD : SBWR;
        end

        LBRD: begin
          memread = 1'b1;
          iord    = 1'b1;
          if (mem_ready)   state_d = LBWR;
          else if (expire) state_d = FETCH1;
          else             state_d = LBRD;
        end

        LBWR: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
          done_d   = 1'b1;
        end

        SBWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
          if (mem_ready) begin
            done_d = 1'b1;
          end else if (!expire) begin
            state_d = SBWR;
          end
        end

        RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
          state_d = RTYPEWR;
        end

        RTYPEWR: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
          done_d   = 1'b1;
        end

        BEQEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = PCSRC_ALUOUT;
          pcen    = zero;
          done_d  = 1'b1;
        end

        JEX: begin
          pcsrc  = PCSRC_JUMP;
          pcen   = 1'b1;
          done_d = 1'b1;
        end

        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          state_d = ADDIWR;
        end

        ADDIWR: begin
          regwrite = 1'b1;
          done_d   = 1'b1;
        end

        default: state_d = FETCH1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller (TIMEOUT=4).
// The stimulus process drives one cycle at a time and queues the
// hand-derived expected output vector for that cycle; a monitor on the
// falling edge pops each entry and compares it with the DUT outputs.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH1  = 4'd0;
  localparam logic [3:0] S_FETCH2  = 4'd1;
  localparam logic [3:0] S_FETCH3  = 4'd2;
  localparam logic [3:0] S_FETCH4  = 4'd3;
  localparam logic [3:0] S_DECODE  = 4'd4;
  localparam logic [3:0] S_MEMADR  = 4'd5;
  localparam logic [3:0] S_LBRD    = 4'd6;
  localparam logic [3:0] S_LBWR    = 4'd7;
  localparam logic [3:0] S_SBWR    = 4'd8;
  localparam logic [3:0] S_RTYPEEX = 4'd9;
  localparam logic [3:0] S_RTYPEWR = 4'd10;
  localparam logic [3:0] S_BEQEX   = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;
  localparam logic [3:0] S_ADDIEX  = 4'd13;
  localparam logic [3:0] S_ADDIWR  = 4'd14;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic [3:0] irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal;
    logic       mem_timeout;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_item_t;

  logic       clk;
  logic       reset;
  logic [3:0] nextstate;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic [3:0] irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;
  logic       mem_timeout;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  multicycle_controller #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .nextstate   (nextstate),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pcen        (pcen),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .regwrite    (regwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .pcsrc       (pcsrc),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .state       (state),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .mem_timeout (mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected strobes for one cycle, written out from the state table.
  // live=0 means the controller is not running yet, so every strobe is 0.
  function automatic obs_t expect_obs(input logic [3:0] st, input logic mr,
                                      input logic z, input logic live,
                                      input logic done, input logic ill,
                                      input logic tmo);
    obs_t o;
    o = '0;
    o.state       = st;
    o.instr_done  = done;
    o.illegal     = ill;
    o.mem_timeout = tmo;
    if (live) begin
      case (st)
        S_FETCH1: begin o.memread = 1; o.alusrcb = 2'b01; o.pcen = mr; o.irwrite = mr ? 4'b0001 : 4'b0000; end
        S_FETCH2: begin o.memread = 1; o.alusrcb = 2'b01; o.pcen = mr; o.irwrite = mr ? 4'b0010 : 4'b0000; end
        S_FETCH3: begin o.memread = 1; o.alusrcb = 2'b01; o.pcen = mr; o.irwrite = mr ? 4'b0100 : 4'b0000; end
        S_FETCH4: begin o.memread = 1; o.alusrcb = 2'b01; o.pcen = mr; o.irwrite = mr ? 4'b1000 : 4'b0000; end
        S_DECODE:  o.alusrcb = 2'b11;
        S_MEMADR:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
        S_LBRD:    begin o.memread = 1; o.iord = 1; end
        S_LBWR:    begin o.regwrite = 1; o.memtoreg = 1; end
        S_SBWR:    begin o.memwrite = 1; o.iord = 1; end
        S_RTYPEEX: begin o.alusrca = 1; o.aluop = 2'b10; end
        S_RTYPEWR: begin o.regwrite = 1; o.regdst = 1; end
        S_BEQEX:   begin o.alusrca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = z; end
        S_JEX:     begin o.pcsrc = 2'b10; o.pcen = 1; end
        S_ADDIEX:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
        S_ADDIWR:  o.regwrite = 1;
        default: ;
      endcase
    end
    return o;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic applyStimulus(input string tag, input logic rst_val,
                               input logic [3:0] ns, input logic z,
                               input logic mr, input logic [3:0] st,
                               input logic live, input logic done,
                               input logic ill, input logic tmo);
    sb_item_t it;
    @(posedge clk);
    #1;
    reset     = rst_val;
    nextstate = ns;
    zero      = z;
    mem_ready = mr;
    it.tag = tag;
    it.exp = expect_obs(st, mr, z, live, done, ill, tmo);
    sb_q.push_back(it);
  endtask

  task automatic cyc(input string tag, input logic [3:0] ns, input logic z,
                     input logic mr, input logic [3:0] st, input logic done,
                     input logic ill, input logic tmo);
    applyStimulus(tag, 1'b1, ns, z, mr, st, 1'b1, done, ill, tmo);
  endtask

  // Four fetch cycles with the memory answering at once.
  task automatic do_fetch(input string tag, input logic [3:0] ns,
                          input logic done, input logic tmo);
    cyc({tag, "/F1"}, ns, 1'b0, 1'b1, S_FETCH1, done, 1'b0, tmo);
    cyc({tag, "/F2"}, ns, 1'b0, 1'b1, S_FETCH2, 1'b0, 1'b0, 1'b0);
    cyc({tag, "/F3"}, ns, 1'b0, 1'b1, S_FETCH3, 1'b0, 1'b0, 1'b0);
    cyc({tag, "/F4"}, ns, 1'b0, 1'b1, S_FETCH4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input sb_item_t it, input obs_t act);
    checks++;
    if (act !== it.exp) begin
      errors++;
      $display("[TB] FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
               it.tag, act.state, act, it.exp.state, it.exp);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation on
  // every falling edge for which one is pending.
  always @(negedge clk) begin
    sb_item_t cur;
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      checkOutput(cur, obs_t'({state, pcen, iord, memread, memwrite, irwrite,
                               regwrite, regdst, memtoreg, pcsrc, alusrca,
                               alusrcb, aluop, instr_done, illegal,
                               mem_timeout}));
    end
  end

  initial begin
    reset     = 1'b0;
    nextstate = 4'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;

    // Held in reset, then released: one quiet cycle before run sets.
    applyStimulus("reset/held0", 1'b0, 4'd0, 1'b0, 1'b0, S_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("reset/held1", 1'b0, 4'd0, 1'b0, 1'b1, S_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("reset/release", 1'b1, S_RTYPEEX, 1'b0, 1'b1, S_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0);

    // R-type: 0,1,2,3,4,9,10 then FETCH1 with instr_done.
    do_fetch("rtype", S_RTYPEEX, 1'b0, 1'b0);
    cyc("rtype/decode", S_RTYPEEX, 1'b0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0);
    cyc("rtype/ex", S_RTYPEEX, 1'b0, 1'b1, S_RTYPEEX, 1'b0, 1'b0, 1'b0);
    cyc("rtype/wr", S_RTYPEEX, 1'b0, 1'b1, S_RTYPEWR, 1'b0, 1'b0, 1'b0);

    // Load byte, memory stalls three cycles; the answer arrives on the
    // last allowed cycle and must beat the watchdog.
    do_fetch("lb", S_LBRD, 1'b1, 1'b0);
    cyc("lb/decode", S_LBRD, 1'b0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0);
    cyc("lb/memadr", S_LBRD, 1'b0, 1'b1, S_MEMADR, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc("lb/rd_stall", S_LBRD, 1'b0, 1'b0, S_LBRD, 1'b0, 1'b0, 1'b0);
    end
    cyc("lb/rd_ready", S_LBRD, 1'b0, 1'b1, S_LBRD, 1'b0, 1'b0, 1'b0);
    cyc("lb/wr", S_LBRD, 1'b0, 1'b1, S_LBWR, 1'b0, 1'b0, 1'b0);

    // Branch taken, then not taken.
    do_fetch("beq1", S_BEQEX, 1'b1, 1'b0);
    cyc("beq1/decode", S_BEQEX, 1'b1, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0);
    cyc("beq1/ex", S_BEQEX, 1'b1, 1'b1, S_BEQEX, 1'b0, 1'b0, 1'b0);
    do_fetch("beq0", S_BEQEX, 1'b1, 1'b0);
    cyc("beq0/decode", S_BEQEX, 1'b0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0);
    cyc("beq0/ex", S_BEQEX, 1'b0, 1'b1, S_BEQEX, 1'b0, 1'b0, 1'b0);

    // Unsupported dispatch code.
    do_fetch("illegal", 4'b0011, 1'b1, 1'b0);
    cyc("illegal/decode", 4'b0011, 1'b0, 1'b1, S_DECODE, 1'b0, 1'b1, 1'b0);

    // Store byte with the memory never answering: four write cycles,
    // then abort reported in the next FETCH1 without instr_done.
    do_fetch("sb_to", S_SBWR, 1'b0, 1'b0);
    cyc("sb_to/decode", S_SBWR, 1'b0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0);
    cyc("sb_to/memadr", S_SBWR, 1'b0, 1'b1, S_MEMADR, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc("sb_to/wr_stall", S_SBWR, 1'b0, 1'b0, S_SBWR, 1'b0, 1'b0, 1'b0);
    end

    // Same store, ready arriving on the fourth cycle.
    do_fetch("sb_ok", S_SBWR, 1'b0, 1'b1);
    cyc("sb_ok/decode", S_SBWR, 1'b0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0);
    cyc("sb_ok/memadr", S_SBWR, 1'b0, 1'b1, S_MEMADR, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc("sb_ok/wr_stall", S_SBWR, 1'b0, 1'b0, S_SBWR, 1'b0, 1'b0, 1'b0);
    end
    cyc("sb_ok/wr_ready", S_SBWR, 1'b0, 1'b1, S_SBWR, 1'b0, 1'b0, 1'b0);

    // Jump, with one stalled fetch cycle in FETCH2.
    cyc("j/F1", S_JEX, 1'b0, 1'b1, S_FETCH1, 1'b1, 1'b0, 1'b0);
    cyc("j/F2_stall", S_JEX, 1'b0, 1'b0, S_FETCH2, 1'b0, 1'b0, 1'b0);
    cyc("j/F2", S_JEX, 1'b0, 1'b1, S_FETCH2, 1'b0, 1'b0, 1'b0);
    cyc("j/F3", S_JEX, 1'b0, 1'b1, S_FETCH3, 1'b0, 1'b0, 1'b0);
    cyc("j/F4", S_JEX, 1'b0, 1'b1, S_FETCH4, 1'b0, 1'b0, 1'b0);
    cyc("j/decode", S_JEX, 1'b0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0);
    cyc("j/ex", S_JEX, 1'b0, 1'b1, S_JEX, 1'b0, 1'b0, 1'b0);

    // Add immediate.
    do_fetch("addi", S_ADDIEX, 1'b1, 1'b0);
    cyc("addi/decode", S_ADDIEX, 1'b0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0);
    cyc("addi/ex", S_ADDIEX, 1'b0, 1'b1, S_ADDIEX, 1'b0, 1'b0, 1'b0);
    cyc("addi/wr", S_ADDIEX, 1'b0, 1'b1, S_ADDIWR, 1'b0, 1'b0, 1'b0);

    // Reset lands in SBWR while memory is ready: write must vanish at once.
    do_fetch("rst", S_SBWR, 1'b1, 1'b0);
    cyc("rst/decode", S_SBWR, 1'b0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0);
    cyc("rst/memadr", S_SBWR, 1'b0, 1'b1, S_MEMADR, 1'b0, 1'b0, 1'b0);
    applyStimulus("rst/assert", 1'b0, S_SBWR, 1'b0, 1'b1, S_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("rst/release", 1'b1, S_SBWR, 1'b0, 1'b1, S_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rst/run", S_SBWR, 1'b0, 1'b1, S_FETCH1, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS core; sequences the shared ALU, register file, IR and byte-wide memory port over FETCH/DECODE/EXECUTE/WRITEBACK.
- Consumes the 4-bit dispatch code `nextstate` produced by the instruction decoder from the IR opcode.
- Drives every datapath strobe.
- Stalls on a memory ready handshake and aborts via a watchdog.

Parameters:
- TIMEOUT, 255: max cycles waiting for mem_ready in one memory state before abort (1..255).
- CNT_W, 8: watchdog counter width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- nextstate  in  4  dispatch code from decoder, valid while IR holds the instruction
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- pcen  out  1  PC load enable
- iord  out  1  0=PC address, 1=ALU-out address
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  4  IR byte-lane load enables, one-hot
- regwrite  out  1  register file write
- regdst  out  1  1=rd, 0=rt
- memtoreg  out  1  1=MDR, 0=ALU-out
- pcsrc  out  2  00=ALU, 01=ALU-out (branch), 10=jump target
- alusrca  out  1  0=PC, 1=rs
- alusrcb  out  2  00=rt, 01=const 1, 10=imm, 11=imm (branch offset)
- aluop  out  2  00=add, 01=sub, 10=funct
- state  out  4  current state, for debug
- instr_done  out  1  one-cycle pulse on return to FETCH1 after a completed instruction
- illegal  out  1  one-cycle pulse: DECODE saw an unsupported dispatch code
- mem_timeout  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset (reset=0, async):
  - state=FETCH1, run=0, watchdog=0, is_load=0.
  - All outputs 0 except state=FETCH1.
- run flag:
  - Sets on the first clk edge after reset release.
  - While run=0, all strobes are forced 0 and the FSM holds FETCH1.
- Outputs are Moore on state (gated by run). Exceptions: irwrite, pcen in FETCHn are qualified by mem_ready; pcen in BEQEX = zero.
- Unlisted outputs are 0. Successor is listed after `->`.
- FETCH1..FETCH4:
  - memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite[k-1]=mem_ready, pcen=mem_ready.
  - Advance to the next fetch state only when mem_ready=1, else hold. FETCH4 -> DECODE.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00.
  - Latch is_load = (nextstate==LBRD).
  - LBRD or SBWR -> MEMADR; RTYPEEX, BEQEX, ADDIEX, JEX -> that state.
  - Any other code -> FETCH1 with illegal=1.
- MEMADR: alusrca=1, alusrcb=10 -> LBRD if is_load else SBWR.
- LBRD: memread=1, iord=1; -> LBWR on mem_ready, else hold.
- LBWR: regwrite=1, memtoreg=1, regdst=0 -> FETCH1.
- SBWR: memwrite=1, iord=1; -> FETCH1 on mem_ready, else hold.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1 -> FETCH1.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero -> FETCH1.
- JEX: pcsrc=10, pcen=1 -> FETCH1.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWR.
- ADDIWR: regwrite=1 -> FETCH1.
- instr_done: pulses in the cycle after LBWR, SBWR-complete, RTYPEWR, BEQEX, JEX or ADDIWR (first cycle of next FETCH1).
- Watchdog:
  - Counts cycles in a memory state (FETCHn, LBRD, SBWR) with mem_ready=0.
  - Clears on mem_ready or on state change.
  - When count reaches TIMEOUT-1 with mem_ready still 0: next state FETCH1, mem_timeout=1, no writes issued.
  - mem_ready in that same cycle wins over timeout.
- Unused state encodings -> FETCH1 next cycle, no strobes asserted.
- Reset mid-instruction: immediate FETCH1 with all strobes 0; no partial write completes after reset asserts.
- Latencies with mem_ready tied 1:
  - R-type 7 cycles, ADDI 7, BEQ 6, J 6, LB 8, SB 7.

Decomposition:
- State encodings go in shared parameter.h (EXMODE_WIDTH=4):
  - FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8.
  - RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14.
- Decoder dispatch codes reuse the same constants.
- Sub-module mem_watchdog (counter, clear, timeout pulse). Next-state and output decode stay in the top.

Test Plan:
- Reset release, mem_ready=1, nextstate=RTYPEEX:
  - states 0,1,2,3,4,9,10,0.
  - irwrite 0001,0010,0100,1000.
  - pcen 4 times; RTYPEWR has regwrite=1, regdst=1; instr_done next cycle.
- nextstate=LBRD, mem_ready low 3 cycles in LBRD:
  - MEMADR -> LBRD held 3 cycles with memread=1, iord=1.
  - Then LBWR with regwrite=1, memtoreg=1.
- BEQEX with zero=1 then repeat with zero=0:
  - pcen=1, pcsrc=01 first time.
  - pcen=0 second time; both return to FETCH1.
- nextstate=4'b0011 at DECODE: illegal=1 for one cycle, next state FETCH1, no regwrite/memwrite.
- TIMEOUT=4, mem_ready held 0 in SBWR:
  - memwrite held 4 cycles, then mem_timeout=1 and FETCH1.
  - Repeat with mem_ready=1 on the 4th cycle: normal completion, no mem_timeout.
- Assert reset during SBWR with mem_ready=1 the same cycle:
  - state=FETCH1 and memwrite=0 immediately.
  - First cycle after release: all strobes 0 (run=0).
